// File: rtl/uart_report_pkg.sv
// uart_report_pkg: shared FSM states, ASCII constants and BCD digit encoding for uart_time_reporter
// Optional feature macro UART_REPORT_PREFIX_EN adds the "T=" line prefix.
package uart_report_pkg;
   typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, FINISH} state_t;
   localparam logic [7:0] CR       = 8'h0D;
   localparam logic [7:0] LF       = 8'h0A;
   localparam logic [7:0] QMARK    = 8'h3F;
   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] PREFIX_0 = 8'h54;
   localparam logic [7:0] PREFIX_1 = 8'h3D;
`ifdef UART_REPORT_PREFIX_EN
   localparam int PREFIX_LEN = 2;
`else
   localparam int PREFIX_LEN = 0;
`endif
   function automatic logic [7:0] bcd_nibble_to_ascii(input logic [3:0] n);
      return (n > 4'd9) ? QMARK : ASCII_0 + {4'd0, n};
   endfunction
endpackage

// File: rtl/uart_report_byte_mux.sv
// uart_report_byte_mux: selects the ASCII byte at a line position from a BCD time snapshot
// Ports: index (byte position), hours_bcd/minutes_bcd/seconds_bcd (snapshot), tx_byte (selected byte).
// UART_REPORT_PREFIX_EN shifts the time fields by two to make room for "T=".
module uart_report_byte_mux
   import uart_report_pkg::*;
#(
   parameter bit         EOL_CRLF = 1'b1,
   parameter logic [7:0] SEP_CHAR = 8'h3A
) (
   input  logic [3:0] index,
   input  logic [7:0] hours_bcd,
   input  logic [7:0] minutes_bcd,
   input  logic [7:0] seconds_bcd,
   output logic [7:0] tx_byte
);
   logic [3:0] pos;
   always_comb begin
      pos = index - 4'(PREFIX_LEN);
      case (pos)
         4'd0:    tx_byte = bcd_nibble_to_ascii(hours_bcd[7:4]);
         4'd1:    tx_byte = bcd_nibble_to_ascii(hours_bcd[3:0]);
         4'd2:    tx_byte = SEP_CHAR;
         4'd3:    tx_byte = bcd_nibble_to_ascii(minutes_bcd[7:4]);
         4'd4:    tx_byte = bcd_nibble_to_ascii(minutes_bcd[3:0]);
         4'd5:    tx_byte = SEP_CHAR;
         4'd6:    tx_byte = bcd_nibble_to_ascii(seconds_bcd[7:4]);
         4'd7:    tx_byte = bcd_nibble_to_ascii(seconds_bcd[3:0]);
         4'd8:    tx_byte = EOL_CRLF ? CR : LF;
         default: tx_byte = LF;
      endcase
`ifdef UART_REPORT_PREFIX_EN
      if (index == 4'd0) tx_byte = PREFIX_0;
      else if (index == 4'd1) tx_byte = PREFIX_1;
`endif
   end
endmodule

// File: rtl/uart_time_reporter.sv
// uart_time_reporter: sends a BCD time snapshot as "HH:MM:SS<EOL>" through a UART TX send/ready handshake
// Ports: clk, reset (sync, active-high), trigger, hours_bcd/minutes_bcd/seconds_bcd (BCD time),
// tx_ready/tx_data/tx_send (UART TX), busy, done, dropped (status pulses).
// Defining UART_REPORT_PREFIX_EN prefixes every line with "T=".
module uart_time_reporter
   import uart_report_pkg::*;
#(
   parameter bit         EOL_CRLF = 1'b1,
   parameter logic [7:0] SEP_CHAR = 8'h3A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       trigger,
   input  logic [7:0] hours_bcd,
   input  logic [7:0] minutes_bcd,
   input  logic [7:0] seconds_bcd,
   input  logic       tx_ready,
   output logic [7:0] tx_data,
   output logic       tx_send,
   output logic       busy,
   output logic       done,
   output logic       dropped
);
   localparam logic [3:0] LAST = 4'(PREFIX_LEN + 8 + (EOL_CRLF ? 2 : 1) - 1);
   state_t     state, state_d;
   logic [3:0] index, index_d;
   logic [7:0] hrs, mins, secs, hrs_d, mins_d, secs_d, next_byte;
   // The mux looks at next-cycle index/snapshot so tx_data is already loaded in the strobe cycle.
   uart_report_byte_mux #(.EOL_CRLF(EOL_CRLF), .SEP_CHAR(SEP_CHAR)) u_mux (
      .index(index_d),
      .hours_bcd(hrs_d),
      .minutes_bcd(mins_d),
      .seconds_bcd(secs_d),
      .tx_byte(next_byte)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         index   <= 4'd0;
         hrs     <= 8'h00;
         mins    <= 8'h00;
         secs    <= 8'h00;
         tx_data <= 8'h00;
         dropped <= 1'b0;
      end else begin
         state   <= state_d;
         index   <= index_d;
         hrs     <= hrs_d;
         mins    <= mins_d;
         secs    <= secs_d;
         tx_data <= (state_d == SEND) ? next_byte : tx_data;
         dropped <= trigger && (state != IDLE);
      end
   end
   always_comb begin
      state_d = state;
      index_d = index;
      hrs_d   = hrs;
      mins_d  = mins;
      secs_d  = secs;
      case (state)
         IDLE: if (trigger) begin
            state_d = SEND;
            index_d = 4'd0;
            hrs_d   = hours_bcd;
            mins_d  = minutes_bcd;
            secs_d  = seconds_bcd;
         end
         SEND:      state_d = tx_ready ? WAIT_BUSY : SEND;
         WAIT_BUSY: state_d = tx_ready ? WAIT_BUSY : WAIT_DONE;
         WAIT_DONE: if (tx_ready) begin
            state_d = (index == LAST) ? FINISH : SEND;
            index_d = (index == LAST) ? index : index + 4'd1;
         end
         default:   state_d = IDLE;
      endcase
   end
   assign tx_send = (state == SEND) && tx_ready;
   assign busy    = (state != IDLE);
   assign done    = (state == FINISH);
endmodule

// File: tb/tb_uart_time_reporter.sv
// tb_uart_time_reporter: directed bench with a UART TX model per DUT (CRLF and LF-only builds)
module tb_uart_time_reporter;
`ifdef UART_REPORT_PREFIX_EN
   localparam int PFX = 2;
`else
   localparam int PFX = 0;
`endif
   localparam int FRAME = 10 * 4;
   typedef struct {
      logic [7:0]  h, m, s;
      int          d;
      int          len;
      logic [79:0] b;
   } vec_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clr = 1'b0;
   logic [1:0] trigger = 2'b00;
   logic [1:0] hold = 2'b00;
   logic [7:0] hours_bcd = 8'h00, minutes_bcd = 8'h00, seconds_bcd = 8'h00;
   logic [1:0] tx_ready, tx_send, busy, done, dropped;
   logic [7:0] tx_data [2];
   logic [1:0] m_rdy = 2'b11;
   int         frame_cnt [2] = '{0, 0};
   logic [7:0] cap [2][16];
   int         cnt [2] = '{0, 0};
   int         dcnt [2] = '{0, 0};
   int         checks = 0, errors = 0;
   vec_t       vt [5];
   always #5 clk = ~clk;
   assign tx_ready = m_rdy & ~hold;
   uart_time_reporter #(.EOL_CRLF(1'b1), .SEP_CHAR(8'h3A)) dut0 (
      .clk(clk), .reset(reset), .trigger(trigger[0]),
      .hours_bcd(hours_bcd), .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd),
      .tx_ready(tx_ready[0]), .tx_data(tx_data[0]), .tx_send(tx_send[0]),
      .busy(busy[0]), .done(done[0]), .dropped(dropped[0])
   );
   uart_time_reporter #(.EOL_CRLF(1'b0), .SEP_CHAR(8'h3A)) dut1 (
      .clk(clk), .reset(reset), .trigger(trigger[1]),
      .hours_bcd(hours_bcd), .minutes_bcd(minutes_bcd), .seconds_bcd(seconds_bcd),
      .tx_ready(tx_ready[1]), .tx_data(tx_data[1]), .tx_send(tx_send[1]),
      .busy(busy[1]), .done(done[1]), .dropped(dropped[1])
   );
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (tx_send[d] && tx_ready[d]) begin
            m_rdy[d]     <= 1'b0;
            frame_cnt[d] <= FRAME;
         end else if (frame_cnt[d] > 1) begin
            frame_cnt[d] <= frame_cnt[d] - 1;
         end else if (frame_cnt[d] == 1) begin
            frame_cnt[d] <= 0;
            m_rdy[d]     <= 1'b1;
         end
         if (clr) begin
            cnt[d]  <= 0;
            dcnt[d] <= 0;
         end else begin
            if (tx_send[d]) begin
               if (cnt[d] < 16) cap[d][cnt[d]] <= tx_data[d];
               cnt[d] <= cnt[d] + 1;
            end
            if (done[d]) dcnt[d] <= dcnt[d] + 1;
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [7:0] exp_b(input vec_t v, input int k);
      if (k < PFX) return (k == 0) ? 8'h54 : 8'h3D;
      return v.b[79 - 8 * (k - PFX) -: 8];
   endfunction
   task automatic clear();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask
   task automatic start(input vec_t v);
      hours_bcd = v.h;
      minutes_bcd = v.m;
      seconds_bcd = v.s;
      trigger[v.d] = 1'b1;
      tick();
      trigger = 2'b00;
   endtask
   task automatic wait_done(input int d);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (done[d]) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk("done_seen", 32'(ok), 1);
   endtask
   task automatic wait_cnt(input int d, input int n);
      bit ok = 0;
      for (int i = 0; i < 2000; i++) begin
         if (cnt[d] >= n) begin
            ok = 1;
            break;
         end
         tick();
      end
      chk("byte_count_reached", 32'(ok), 1);
   endtask
   task automatic check_line(input vec_t v);
      chk("line_len", 32'(cnt[v.d]), 32'(v.len + PFX));
      for (int k = 0; k < v.len + PFX; k++) chk($sformatf("byte%0d_dut%0d", k, v.d), {24'd0, cap[v.d][k]}, {24'd0, exp_b(v, k)});
      chk("done_pulses", 32'(dcnt[v.d]), 1);
   endtask
   initial begin
      vt[0] = '{8'h12, 8'h34, 8'h56, 0, 10, 80'h31323A33343A35360D0A};
      vt[1] = '{8'h23, 8'h59, 8'h09, 1, 9, 80'h32333A35393A30390A00};
      vt[2] = '{8'h1C, 8'h00, 8'h00, 0, 10, 80'h313F3A30303A30300D0A};
      vt[3] = '{8'h00, 8'h00, 8'h00, 0, 10, 80'h30303A30303A30300D0A};
      vt[4] = '{8'h99, 8'hAF, 8'hF0, 1, 9, 80'h39393A3F3F3A3F300A00};
      tick();
      tick();
      for (int d = 0; d < 2; d++) begin
         chk("rst_tx_data", {24'd0, tx_data[d]}, 0);
         chk("rst_tx_send", 32'(tx_send[d]), 0);
         chk("rst_busy", 32'(busy[d]), 0);
         chk("rst_done", 32'(done[d]), 0);
         chk("rst_dropped", 32'(dropped[d]), 0);
      end
      reset = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         clear();
         start(vt[i]);
         chk("first_send_latency", 32'(tx_send[vt[i].d]), 1);
         hours_bcd = 8'h77;
         minutes_bcd = 8'h88;
         seconds_bcd = 8'h11;
         wait_done(vt[i].d);
         tick();
         chk("busy_after_line", 32'(busy[vt[i].d]), 0);
         check_line(vt[i]);
      end
      clear();
      start(vt[0]);
      wait_cnt(0, 3);
      trigger[0] = 1'b1;
      tick();
      trigger = 2'b00;
      chk("dropped_mid_line", 32'(dropped[0]), 1);
      chk("busy_mid_line", 32'(busy[0]), 1);
      wait_done(0);
      trigger[0] = 1'b1;
      tick();
      trigger = 2'b00;
      chk("dropped_finish", 32'(dropped[0]), 1);
      chk("idle_after_finish", 32'(busy[0]), 0);
      repeat (60) tick();
      chk("no_second_line_busy", 32'(busy[0]), 0);
      check_line(vt[0]);
      clear();
      hold[0] = 1'b1;
      start(vt[0]);
      begin
         int sends = 0;
         for (int i = 0; i < 20; i++) begin
            if (tx_send[0]) sends++;
            tick();
         end
         chk("no_send_while_not_ready", 32'(sends), 0);
      end
      chk("busy_while_held", 32'(busy[0]), 1);
      hold[0] = 1'b0;
      #1;
      chk("send_on_ready", 32'(tx_send[0]), 1);
      wait_done(0);
      tick();
      check_line(vt[0]);
      clear();
      start(vt[0]);
      wait_cnt(0, 6);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_tx_send", 32'(tx_send[0]), 0);
      chk("abort_tx_data", {24'd0, tx_data[0]}, 0);
      chk("abort_busy", 32'(busy[0]), 0);
      chk("abort_done", 32'(done[0]), 0);
      chk("abort_dropped", 32'(dropped[0]), 0);
      clear();
      start(vt[0]);
      chk("no_send_uart_busy", 32'(tx_send[0]), 0);
      chk("busy_after_retrigger", 32'(busy[0]), 1);
      wait_done(0);
      tick();
      check_line(vt[0]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
